// File: rtl/conv_writeback.sv
// Output writeback for the conv NPU: captures per-PE result groups into a small FIFO
// and serializes the set lanes into FRAM, one word per accepted write.
module conv_writeback #(
  parameter int PE_NUM      = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int GROUP_DEPTH = 4,
  parameter int ADDR_STEP   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        output_baseaddr,
  input  logic [PE_NUM-1:0]        out_en,
  input  logic [PE_NUM*DATA_W-1:0] pe_result,
  input  logic                     flush,
  output logic                     wb_busy,
  output logic                     fram_wr_en,
  output logic [ADDR_W-1:0]        fram_wr_addr,
  output logic [DATA_W-1:0]        fram_wr_data,
  input  logic                     fram_wr_ready,
  output logic                     done,
  output logic                     overflow,
  output logic [31:0]              words_written
);

  localparam int PTR_W  = (GROUP_DEPTH > 1) ? $clog2(GROUP_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [PE_NUM-1:0]         mask_q [GROUP_DEPTH];
  logic [PE_NUM*DATA_W-1:0]  data_q [GROUP_DEPTH];
  logic [PTR_W-1:0]          rd_ptr_q, wr_idx_q;
  logic [CNT_W-1:0]          count_q;
  logic [ADDR_W-1:0]         wr_ptr_q;
  logic [31:0]               words_q;
  logic                      overflow_q;

  logic                      empty, full, wr_active, fire, push, pop, drop, found;
  logic [PE_NUM-1:0]         head_mask, mask_next;
  logic [PE_NUM*DATA_W-1:0]  head_data;
  logic [LANE_W-1:0]         lane_sel;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(GROUP_DEPTH));
  assign head_mask = mask_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  always_comb begin
    lane_sel = '0;
    found    = 1'b0;
    for (int i = 0; i < PE_NUM; i++) begin
      if (head_mask[i] && !found) begin
        lane_sel = LANE_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign wr_active = !empty && (state_q == S_RUN || state_q == S_DRAIN);
  assign fire      = wr_active && fram_wr_ready;
  assign mask_next = head_mask & ~(PE_NUM'(1) << lane_sel);
  assign pop       = fire && (mask_next == '0);
  assign push      = (state_q == S_RUN) && (|out_en) && !full;
  assign drop      = (state_q == S_RUN) && (|out_en) && full;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (flush) state_d = S_DRAIN;
      S_DRAIN: if (empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_idx_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      words_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_idx_q <= wr_idx_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (state_q == S_IDLE && start) begin
        wr_ptr_q   <= output_baseaddr;
        words_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (fire) begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(ADDR_STEP);
          words_q  <= words_q + 32'd1;
        end
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

  // Push only lands in a free slot, so it never aliases the head being consumed.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_q[wr_idx_q] <= out_en;
      data_q[wr_idx_q] <= pe_result;
    end
    if (fire) mask_q[rd_ptr_q] <= mask_next;
  end

  assign fram_wr_en    = wr_active;
  assign fram_wr_addr  = wr_ptr_q;
  assign fram_wr_data  = wr_active ? head_data[lane_sel*DATA_W +: DATA_W] : '0;
  assign wb_busy       = (state_q == S_RUN && count_q >= CNT_W'(GROUP_DEPTH - 1)) ||
                         state_q == S_DRAIN || state_q == S_DONE;
  assign done          = (state_q == S_DONE);
  assign overflow      = overflow_q;
  assign words_written = words_q;

endmodule

// File: doc/conv_writeback.md
Name: conv_writeback

Overview:
- Output writeback unit of the conv NPU; the consumer end of the decoder's PE-control interface.
- Captures per-PE results when `out_en` is set and serializes them into FRAM word by word, starting at the layer's `output_baseaddr`.
- Drives `wb_busy` back to the decoder as backpressure.
- Handles `flush` as end-of-layer: drains, then signals completion.

Parameters:
- PE_NUM, 4, number of PE lanes (matches the decoder's PE_NUM).
- DATA_W, 32, width of one PE result word.
- ADDR_W, 32, FRAM byte-address width.
- GROUP_DEPTH, 4, number of PE_NUM-word groups the capture FIFO holds (power of two, ≥2).
- ADDR_STEP, 4, byte increment per word written.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse when the decoder accepts an instruction (inst_valid & decoder_ready).
- output_baseaddr  in  ADDR_W  layer output base address; sampled on an accepted start.
- out_en  in  PE_NUM  per-lane result-valid from the decoder.
- pe_result  in  PE_NUM*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- flush  in  1  end-of-layer pulse from the decoder.
- wb_busy  out  1  backpressure to the decoder.
- fram_wr_en  out  1  write request.
- fram_wr_addr  out  ADDR_W  write byte address.
- fram_wr_data  out  DATA_W  write data.
- fram_wr_ready  in  1  FRAM accepts a write in a cycle where en & ready.
- done  out  1  one-cycle pulse when the layer is fully written.
- overflow  out  1  sticky: a group was dropped because the FIFO was full.
- words_written  out  32  count of words accepted by FRAM this layer.

Behaviour:
- Reset: state=IDLE; FIFO empty; wr_ptr=0; all outputs 0 (wb_busy=0, fram_wr_en=0, fram_wr_addr=0, fram_wr_data=0, done=0, overflow=0, words_written=0). Reset mid-operation discards all buffered data and writes nothing further.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start → RUN. Same edge loads wr_ptr<=output_baseaddr and clears words_written and overflow.
  - start in any other state is ignored.
- Capture (RUN only):
  - out_en≠0 and FIFO not full → push {out_en, pe_result} at the clock edge.
  - out_en=0 → no push.
  - FIFO full and out_en≠0 → group dropped, overflow<=1.
  - out_en and flush in the same cycle: capture the group first, then go to DRAIN.
  - out_en is ignored in IDLE, DRAIN and DONE.
- Serializer:
  - Head entry keeps a working copy of its mask.
  - fram_wr_en = FIFO non-empty and state in {RUN, DRAIN}.
  - fram_wr_data = lane word of the lowest set mask bit; fram_wr_addr = wr_ptr. All three are combinational from registered state.
  - On en&ready: clear that mask bit, wr_ptr += ADDR_STEP (wraps modulo 2^ADDR_W), words_written += 1.
  - When the mask becomes zero, pop the entry that cycle. Next head's first word is presented the following cycle.
  - Word order is ascending lane within a group, groups in arrival order.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - fram_wr_addr/data must stay stable while en=1 and ready=0.
- wb_busy:
  - 1 when (state==RUN and occupancy ≥ GROUP_DEPTH-1), or state in {DRAIN, DONE}; else 0.
  - Combinational from registered state.
  - One slot of slack absorbs a group the decoder emits in the same cycle it sees busy.
- DRAIN: wait until FIFO empty and no write in flight → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- Throughput: 1 word/cycle with ready=1. Capture-to-first-write latency is 1 cycle: push at edge N, fram_wr_en=1 during cycle N+1.

Test Plan:
1. Single group, ready=1, PE_NUM=4:
   - Stimulus: base=0x0040_0000, start, one cycle out_en=4'b1111 with results 1,2,3,4, then flush.
   - Response: writes to 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C with data 1,2,3,4 on consecutive cycles; done pulses once; words_written=4.
2. Sparse mask:
   - Stimulus: out_en=4'b1010 with lanes {10,11,12,13}.
   - Response: exactly two writes, data 11 then 13, at base and base+4.
3. Backpressure:
   - Stimulus: fram_wr_ready=0; push groups every cycle.
   - Response: wb_busy rises once occupancy reaches 3; a push while full (4) sets overflow=1; address/data held stable; after ready=1 all stored words drain in order.
4. Flush with data:
   - Stimulus: out_en=4'b0001 and flush in the same cycle.
   - Response: the group is captured and written; wb_busy=1 from the next cycle until done; done occurs only after the last write.
5. Reset mid-run:
   - Stimulus: assert rst while 2 groups are buffered and en=1.
   - Response: next cycle fram_wr_en=0, wb_busy=0, words_written=0, state IDLE; a start after that restarts cleanly from the new base.
6. Wrap and ignored start:
   - Stimulus: base=0xFFFF_FFFC with 2 words; also pulse start during RUN.
   - Response: addresses 0xFFFF_FFFC then 0x0000_0000; the second start has no effect.
